// File: rtl/led_ctrl_slave.sv
// LED controller behind an Avalon-MM slave: byte-wise command parser,
// prescaled step timing, and static/blink/rotate LED pattern modes.
module led_ctrl_slave #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic       clk_clk,
    input  logic       reset_sink_reset,
    input  logic       avalon_slave_read,
    input  logic       avalon_slave_write,
    input  logic [7:0] avalon_slave_writedata,
    output logic [7:0] avalon_slave_readdata,
    output logic [7:0] leds
);

    typedef enum logic {
        P_IDLE,
        P_ARG
    } parser_t;

    typedef enum logic [1:0] {
        MODE_STATIC,
        MODE_BLINK,
        MODE_ROTL,
        MODE_ROTR
    } mode_t;

    localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);
    localparam logic [5:0]  CMD_PREFIX   = 6'b101000;

    parser_t     parser_q, parser_d;
    logic [1:0]  opcode_q, opcode_d;
    logic [7:0]  pattern_q, pattern_d;
    mode_t       mode_q, mode_d;
    logic [7:0]  rate_q, rate_d;
    logic        phase_q, phase_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  step_cnt_q, step_cnt_d;
    logic [7:0]  leds_q, leds_d;
    logic [7:0]  readdata_q, readdata_d;

    logic        apply;
    logic        cmd_valid;
    logic        tick;
    logic        step;

    // Classify the written byte: argument for a pending command, or a new command.
    always_comb begin
        apply     = avalon_slave_write && (parser_q == P_ARG);
        cmd_valid = avalon_slave_write && (parser_q == P_IDLE)
                    && (avalon_slave_writedata[7:2] == CMD_PREFIX);
    end

    // Prescaler and step counter; an applied argument restarts timing from zero.
    always_comb begin
        tick       = (presc_q == PRESCALE_MAX);
        step       = tick && ((step_cnt_q + 8'd1) >= rate_q);
        presc_d    = tick ? 16'd0 : presc_q + 16'd1;
        step_cnt_d = step_cnt_q;
        if (step) begin
            step_cnt_d = 8'd0;
        end else if (tick) begin
            step_cnt_d = step_cnt_q + 8'd1;
        end
        if (apply) begin
            presc_d    = 16'd0;
            step_cnt_d = 8'd0;
        end
    end

    // Command parser: a valid command waits in ARG for exactly one argument byte.
    always_comb begin
        parser_d = parser_q;
        opcode_d = opcode_q;
        if (cmd_valid) begin
            parser_d = P_ARG;
            opcode_d = avalon_slave_writedata[1:0];
        end else if (apply) begin
            parser_d = P_IDLE;
        end
    end

    // Display state: an applied argument takes priority over a coincident step.
    always_comb begin
        pattern_d = pattern_q;
        mode_d    = mode_q;
        rate_d    = rate_q;
        phase_d   = phase_q;
        if (apply) begin
            phase_d = 1'b0;
            case (opcode_q)
                2'd0: pattern_d = avalon_slave_writedata;
                2'd1: mode_d    = mode_t'(avalon_slave_writedata[1:0]);
                2'd2: rate_d    = (avalon_slave_writedata == 8'd0) ? 8'd1
                                                                   : avalon_slave_writedata;
                default: begin
                    pattern_d = 8'h00;
                    mode_d    = MODE_STATIC;
                end
            endcase
        end else if (step) begin
            case (mode_q)
                MODE_BLINK: phase_d   = ~phase_q;
                MODE_ROTL:  pattern_d = {pattern_q[6:0], pattern_q[7]};
                MODE_ROTR:  pattern_d = {pattern_q[0], pattern_q[7:1]};
                default:    pattern_d = pattern_q;
            endcase
        end
    end

    // Registered outputs: LED drive and read-back snapshot of pre-write state.
    always_comb begin
        leds_d     = ((mode_q == MODE_BLINK) && phase_q) ? 8'h00 : pattern_q;
        readdata_d = readdata_q;
        if (avalon_slave_read) begin
            readdata_d = (parser_q == P_ARG) ? {CMD_PREFIX, opcode_q} : leds_q;
        end
    end

    // State register with synchronous reset; strobes are ignored during reset.
    always_ff @(posedge clk_clk) begin
        if (reset_sink_reset) begin
            parser_q   <= P_IDLE;
            opcode_q   <= 2'd0;
            pattern_q  <= 8'h00;
            mode_q     <= MODE_STATIC;
            rate_q     <= 8'd1;
            phase_q    <= 1'b0;
            presc_q    <= 16'd0;
            step_cnt_q <= 8'd0;
            leds_q     <= 8'h00;
            readdata_q <= 8'h00;
        end else begin
            parser_q   <= parser_d;
            opcode_q   <= opcode_d;
            pattern_q  <= pattern_d;
            mode_q     <= mode_d;
            rate_q     <= rate_d;
            phase_q    <= phase_d;
            presc_q    <= presc_d;
            step_cnt_q <= step_cnt_d;
            leds_q     <= leds_d;
            readdata_q <= readdata_d;
        end
    end

    assign leds                  = leds_q;
    assign avalon_slave_readdata = readdata_q;

endmodule

// File: tb/tb_led_ctrl_slave.sv
// Testbench for led_ctrl_slave: directed vector table, hand-written timing
// sequences, and randomized traffic against a behavioural model.
module tb_led_ctrl_slave;

    localparam int PRESC = 4;

    logic       clk;
    logic       rst;
    logic       rd;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] readdata;
    logic [7:0] leds;

    int vectors    = 0;
    int miscompares = 0;

    led_ctrl_slave #(.PRESCALE(PRESC)) dut (
        .clk_clk                (clk),
        .reset_sink_reset       (rst),
        .avalon_slave_read      (rd),
        .avalon_slave_write     (wr),
        .avalon_slave_writedata (wdata),
        .avalon_slave_readdata  (readdata),
        .leds                   (leds)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: timing is tracked as edges since the last restart.
    logic [7:0] m_pattern = 8'h00;
    logic [7:0] m_rate    = 8'd1;
    logic [7:0] m_leds    = 8'h00;
    logic [7:0] m_rd      = 8'h00;
    logic [1:0] m_op      = 2'd0;
    int         m_mode    = 0;
    bit         m_phase   = 1'b0;
    bit         m_arg     = 1'b0;
    int         m_n       = 0;

    task automatic modelEdge(input bit r, input bit rdi, input bit wri, input logic [7:0] d);
        logic [7:0] next_leds;
        bit         st;
        if (r) begin
            m_pattern = 8'h00; m_rate = 8'd1; m_leds = 8'h00; m_rd = 8'h00;
            m_op = 2'd0; m_mode = 0; m_phase = 1'b0; m_arg = 1'b0; m_n = 0;
        end else begin
            next_leds = (m_mode == 1 && m_phase) ? 8'h00 : m_pattern;
            if (rdi) m_rd = m_arg ? (8'hA0 + {6'd0, m_op}) : m_leds;
            m_leds = next_leds;
            if (wri && m_arg) begin
                case (m_op)
                    2'd0: m_pattern = d;
                    2'd1: m_mode = int'(d % 4);
                    2'd2: m_rate = (d == 8'd0) ? 8'd1 : d;
                    default: begin m_pattern = 8'h00; m_mode = 0; end
                endcase
                m_n = 0; m_phase = 1'b0; m_arg = 1'b0;
            end else begin
                st = ((m_n + 1) % (PRESC * int'(m_rate))) == 0;
                m_n++;
                if (st) begin
                    if (m_mode == 1) m_phase = ~m_phase;
                    else if (m_mode == 2) m_pattern = (m_pattern << 1) | (m_pattern >> 7);
                    else if (m_mode == 3) m_pattern = (m_pattern >> 1) | (m_pattern << 7);
                end
                if (wri && d >= 8'hA0 && d <= 8'hA3) begin
                    m_arg = 1'b1;
                    m_op  = 2'(d - 8'hA0);
                end
            end
        end
    endtask

    // Drive one cycle of inputs on the falling edge, advance the model at the
    // rising edge, and return 1 time unit later for sampling.
    task automatic applyStimulus(input bit r, input bit rdi, input bit wri, input logic [7:0] d);
        @(negedge clk);
        rst = r; rd = rdi; wr = wri; wdata = d;
        @(posedge clk);
        modelEdge(r, rdi, wri, d);
        #1;
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic writeByte(input logic [7:0] d);
        applyStimulus(1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         r;
        bit         rdi;
        bit         wri;
        logic [7:0] d;
        bit         chk_l;
        logic [7:0] exp_l;
        bit         chk_r;
        logic [7:0] exp_r;
    } vec_t;

    vec_t tbl [24];

    // Main test sequence.
    initial begin
        logic [7:0] cur;
        logic [7:0] nxt;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; wdata = 8'h00;

        tbl[0]  = '{1, 0, 0, 8'h00, 1, 8'h00, 1, 8'h00};
        tbl[1]  = '{0, 0, 1, 8'hA0, 1, 8'h00, 0, 8'h00};
        tbl[2]  = '{0, 1, 0, 8'h00, 1, 8'h00, 1, 8'hA0};
        tbl[3]  = '{0, 0, 1, 8'h5A, 1, 8'h00, 0, 8'h00};
        tbl[4]  = '{0, 0, 0, 8'h00, 1, 8'h5A, 1, 8'hA0};
        tbl[5]  = '{0, 1, 0, 8'h00, 0, 8'h00, 1, 8'h5A};
        tbl[6]  = '{0, 0, 1, 8'h37, 1, 8'h5A, 0, 8'h00};
        tbl[7]  = '{0, 0, 1, 8'h11, 1, 8'h5A, 0, 8'h00};
        tbl[8]  = '{0, 0, 1, 8'hA0, 0, 8'h00, 0, 8'h00};
        tbl[9]  = '{0, 1, 0, 8'h00, 0, 8'h00, 1, 8'hA0};
        tbl[10] = '{1, 0, 0, 8'h00, 1, 8'h00, 1, 8'h00};
        tbl[11] = '{0, 0, 1, 8'h55, 1, 8'h00, 0, 8'h00};
        tbl[12] = '{0, 1, 0, 8'h00, 0, 8'h00, 1, 8'h00};
        tbl[13] = '{0, 0, 1, 8'hA0, 0, 8'h00, 0, 8'h00};
        tbl[14] = '{0, 0, 1, 8'h55, 0, 8'h00, 0, 8'h00};
        tbl[15] = '{0, 0, 0, 8'h00, 1, 8'h55, 0, 8'h00};
        tbl[16] = '{1, 1, 1, 8'hA0, 1, 8'h00, 1, 8'h00};
        tbl[17] = '{0, 0, 1, 8'h5A, 0, 8'h00, 0, 8'h00};
        tbl[18] = '{0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00};
        tbl[19] = '{0, 1, 0, 8'h00, 0, 8'h00, 1, 8'h00};
        tbl[20] = '{0, 1, 1, 8'hA0, 0, 8'h00, 1, 8'h00};
        tbl[21] = '{0, 1, 1, 8'h81, 0, 8'h00, 1, 8'hA0};
        tbl[22] = '{0, 0, 0, 8'h00, 1, 8'h81, 0, 8'h00};
        tbl[23] = '{0, 1, 0, 8'h00, 0, 8'h00, 1, 8'h81};

        $display("[TB] directed vector table");
        for (int i = 0; i < 24; i++) begin
            applyStimulus(tbl[i].r, tbl[i].rdi, tbl[i].wri, tbl[i].d);
            if (tbl[i].chk_l) checkOutput($sformatf("table%0d_leds", i), leds, tbl[i].exp_l);
            if (tbl[i].chk_r) checkOutput($sformatf("table%0d_readdata", i), readdata, tbl[i].exp_r);
        end

        $display("[TB] rotate-left sequence, rate 2");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        writeByte(8'hA0); writeByte(8'h81);
        writeByte(8'hA2); writeByte(8'h02);
        writeByte(8'hA1); writeByte(8'h02);
        cur = 8'h81;
        runIdle(7);
        for (int s = 0; s < 3; s++) begin
            nxt = {cur[6:0], cur[7]};
            runIdle(1);
            checkOutput($sformatf("rotl_hold%0d", s), leds, cur);
            runIdle(1);
            checkOutput($sformatf("rotl_step%0d", s), leds, nxt);
            runIdle(6);
            cur = nxt;
        end

        $display("[TB] blink sequence then clear");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        writeByte(8'hA0); writeByte(8'hFF);
        writeByte(8'hA1); writeByte(8'h01);
        runIdle(4); checkOutput("blink_on_a", leds, 8'hFF);
        runIdle(1); checkOutput("blink_off_a", leds, 8'h00);
        runIdle(3); checkOutput("blink_off_b", leds, 8'h00);
        runIdle(1); checkOutput("blink_on_b", leds, 8'hFF);
        writeByte(8'hA3); writeByte(8'h00);
        for (int i = 0; i < 12; i++) begin
            runIdle(1);
            checkOutput($sformatf("clear_hold%0d", i), leds, 8'h00);
        end

        $display("[TB] rotate-right with rate 0 argument");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        writeByte(8'hA0); writeByte(8'h01);
        writeByte(8'hA2); writeByte(8'h00);
        writeByte(8'hA1); writeByte(8'h03);
        runIdle(4); checkOutput("rotr_before", leds, 8'h01);
        runIdle(1); checkOutput("rotr_first", leds, 8'h80);
        runIdle(4); checkOutput("rotr_second", leds, 8'h40);

        $display("[TB] randomized traffic against model");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4000; i++) begin
            bit         r_r;
            bit         r_rd;
            bit         r_wr;
            logic [7:0] r_d;
            r_r  = ($urandom_range(0, 199) == 0);
            r_rd = ($urandom_range(0, 3) == 0);
            r_wr = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       r_d = 8'hA0 | 8'($urandom_range(0, 3));
                1:       r_d = 8'($urandom_range(0, 3));
                2:       r_d = 8'($urandom);
                default: r_d = 8'($urandom_range(0, 2));
            endcase
            applyStimulus(r_r, r_rd, r_wr, r_d);
            checkOutput("rand_leds", leds, m_leds);
            checkOutput("rand_readdata", readdata, m_rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_ctrl_slave.md
LED_CTRL_SLAVE -- requirements
Module: led_ctrl_slave

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000; clk_clk cycles per tick (1 kHz at 50 MHz); legal range 2..65535.
REQ-002 SHALL have port clk_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_sink_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port avalon_slave_read  input  1  Avalon-MM read strobe.
REQ-005 SHALL have port avalon_slave_write  input  1  Avalon-MM write strobe.
REQ-006 SHALL have port avalon_slave_writedata  input  8  command or argument byte.
REQ-007 SHALL have port avalon_slave_readdata  output  8  registered status/LED readback.
REQ-008 SHALL have port leds  output  8  LED drive, registered, 1 = on.

Function
REQ-009 SHALL treat each cycle with avalon_slave_write=1 as exactly one accepted byte; no waitrequest, zero write wait states.
REQ-010 SHALL run a two-state parser, IDLE and ARG; IDLE accepts a command byte, ARG accepts its argument byte.
REQ-011 SHALL accept command bytes 0xA0..0xA3 only (bits[7:2]=6'b101000; opcode = bits[1:0]); any other byte in IDLE is ignored and the parser stays IDLE.
REQ-012 SHALL on a valid command store the opcode and move IDLE->ARG; in ARG the next written byte is the argument and the parser returns to IDLE, with no validity check on that byte.
REQ-013 SHALL apply the argument on the cycle after it is written: opcode 0 SET_PATTERN (pattern<=arg), 1 SET_MODE (mode<=arg[1:0], arg[7:2] ignored), 2 SET_RATE (rate<=arg; 0 stored as 1), 3 CLEAR (pattern<=0, mode<=0, argument ignored).
REQ-014 SHALL implement modes: 0 STATIC, 1 BLINK, 2 ROTL, 3 ROTR.
REQ-015 SHALL run a prescaler counting 0..PRESCALE-1 and pulse tick for one cycle when it wraps.
REQ-016 SHALL run a step counter incremented on tick; when it reaches rate it clears and emits a one-cycle step.
REQ-017 SHALL on step: in BLINK toggle phase; in ROTL rotate pattern left by 1 (bit7->bit0); in ROTR rotate right by 1 (bit0->bit7); in STATIC do nothing.
REQ-018 SHALL drive leds <= (mode==BLINK && phase==1) ? 8'h00 : pattern, registered, updating one cycle after any change in pattern, mode or phase.
REQ-019 SHALL clear prescaler, step counter and phase whenever any argument is applied (REQ-013), so timing restarts from the write.
REQ-020 SHALL when an argument apply and a step fall in the same cycle, let the argument win; the step is discarded.
REQ-021 SHALL on avalon_slave_read=1 load avalon_slave_readdata on the next edge (fixed read latency 1) with the current leds value when the parser is IDLE, or 8'hA0|opcode when the parser is in ARG; otherwise hold its value.
REQ-022 SHALL when read and write occur in the same cycle service both; readdata reflects the pre-write state.

Reset
REQ-023 SHALL while reset_sink_reset=1 at an edge set leds=0x00, avalon_slave_readdata=0x00, pattern=0x00, mode=STATIC, rate=1, phase=0, both counters=0 and parser=IDLE.
REQ-024 SHALL when reset is asserted with the parser in ARG discard the pending command; the first byte after reset is parsed as a command.
REQ-025 SHALL ignore read and write strobes in any cycle where reset_sink_reset=1.

Verification (PRESCALE=4)
REQ-026 Write 0xA0,0x5A -> leds=0x5A two cycles after the second write; read -> readdata=0x5A one cycle later.
REQ-027 Pattern 0x81, write 0xA2,0x02 then 0xA1,0x02 (ROTL) -> leds steps 0x81, 0x03, 0x06, 0x0C, with 8 cycles between steps.
REQ-028 Pattern 0xFF, mode BLINK, rate 1 -> leds alternates 0xFF/0x00 every 4 cycles; writing 0xA3,0x00 -> leds=0x00 and stays 0x00.
REQ-029 Write 0x37 then 0x11 in IDLE -> both ignored, state unchanged; write 0xA0, then read -> readdata=0xA0.
REQ-030 Write 0xA0, assert reset for 1 cycle, write 0x55 -> 0x55 ignored as an invalid command, leds=0x00.
REQ-031 Write 0xA2,0x00 -> rate=1 (step every tick); ROTR on 0x01 -> leds=0x80 after the first step.
